// File: rtl/sample_window_scheduler_if.sv
// Request/grant and window-status signals between the measurement units and the
// shared sampling-window timer.
interface sample_window_scheduler_if #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 32
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     req_i;
    logic [NUM_REQ-1:0]     grant_o;
    logic                   busy_o;
    logic                   tick_o;
    logic [COUNT_WIDTH-1:0] tick_count_o;
    logic                   window_done_o;
    logic [ID_WIDTH-1:0]    done_id_o;

    // Scheduler side
    modport master (
        input  req_i,
        output grant_o, busy_o, tick_o, tick_count_o, window_done_o, done_id_o
    );

    // Requester side
    modport slave (
        output req_i,
        input  grant_o, busy_o, tick_o, tick_count_o, window_done_o, done_id_o
    );
endinterface

// File: rtl/sample_window_scheduler.sv
// Round-robin scheduler that lends one prescaled sampling-window timer to NUM_REQ
// requesters and reports each completed window with the owner's index.
module sample_window_scheduler #(
    parameter int NUM_REQ            = 4,
    parameter int SYSTEM_FREQUENCY   = 100000000,
    parameter int SAMPLING_FREQUENCY = 1000000,
    parameter int WINDOW_TICKS       = 125000,
    parameter int COUNT_WIDTH        = 32
) (
    input  logic                            clock_i,
    input  logic                            reset_n_i,
    sample_window_scheduler_if.master       bus
);
    localparam int DIV         = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
    localparam int PRESC_WIDTH = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ID_WIDTH    = $clog2(NUM_REQ);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                 state_q,   state_d;
    logic [PRESC_WIDTH-1:0] presc_q,   presc_d;
    logic [COUNT_WIDTH-1:0] count_q,   count_d;
    logic [ID_WIDTH-1:0]    gidx_q,    gidx_d;
    logic [ID_WIDTH-1:0]    ptr_q,     ptr_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic [ID_WIDTH-1:0]    done_id_q, done_id_d;

    logic                   tick;
    logic                   found;
    logic [ID_WIDTH-1:0]    sel;
    logic [ID_WIDTH-1:0]    ptr_after;
    int                     idx;

    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_WIDTH'(DIV - 1));
    assign ptr_after = (gidx_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    // First requesting index at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && bus.req_i[ID_WIDTH'(idx)]) begin
                found = 1'b1;
                sel   = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_RUN;
                    gidx_d  = sel;
                    busy_d  = 1'b1;
                    presc_d = '0;
                    count_d = '0;
                end
            end
            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                // Losing the request beats completion on the same edge
                if (!bus.req_i[gidx_q]) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    count_d = '0;
                    ptr_d   = ptr_after;
                end else if (tick) begin
                    count_d = count_q + 1'b1;
                    if (count_q == COUNT_WIDTH'(WINDOW_TICKS - 1)) begin
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        done_id_d = gidx_q;
                        ptr_d     = ptr_after;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    // Grant is decoded from the owner index, so it can only be zero or one-hot
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign bus.grant_o[gi] = busy_q && (gidx_q == ID_WIDTH'(gi));
    end

    assign bus.busy_o        = busy_q;
    assign bus.tick_o        = tick;
    assign bus.tick_count_o  = count_q;
    assign bus.window_done_o = done_q;
    assign bus.done_id_o     = done_id_q;
endmodule

// File: tb/tb_sample_window_scheduler.sv
// Directed bench: DIV=4/WINDOW_TICKS=3 instance for the main scenarios and a
// DIV=1/WINDOW_TICKS=1 instance for the degenerate timing case.
module tb_sample_window_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rr_ids [4] = '{0, 1, 3, 0};

    always #5 clk = ~clk;

    sample_window_scheduler_if #(.NUM_REQ(4), .COUNT_WIDTH(32)) a ();
    sample_window_scheduler_if #(.NUM_REQ(4), .COUNT_WIDTH(32)) b ();

    sample_window_scheduler #(
        .NUM_REQ(4), .SYSTEM_FREQUENCY(8), .SAMPLING_FREQUENCY(2),
        .WINDOW_TICKS(3), .COUNT_WIDTH(32)
    ) dut_a (
        .clock_i(clk), .reset_n_i(rst_n), .bus(a)
    );

    sample_window_scheduler #(
        .NUM_REQ(4), .SYSTEM_FREQUENCY(1), .SAMPLING_FREQUENCY(1),
        .WINDOW_TICKS(1), .COUNT_WIDTH(32)
    ) dut_b (
        .clock_i(clk), .reset_n_i(rst_n), .bus(b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_a_quiet(input string tag);
        chk({tag, "_grant"}, 32'(a.grant_o), 32'h0);
        chk({tag, "_busy"},  32'(a.busy_o), 32'h0);
        chk({tag, "_tick"},  32'(a.tick_o), 32'h0);
        chk({tag, "_count"}, a.tick_count_o, 32'h0);
        chk({tag, "_done"},  32'(a.window_done_o), 32'h0);
        chk({tag, "_id"},    32'(a.done_id_o), 32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        a.req_i = '0;
        b.req_i = '0;
        cyc(); cyc();
        chk_a_quiet("reset");
        rst_n = 1'b1;

        // No requests: stays idle
        repeat (3) cyc();
        chk_a_quiet("idle_noreq");

        // Single request, exact tick placement and window length
        a.req_i = 4'b0001;
        cyc();
        chk("single_busy", 32'(a.busy_o), 32'h1);
        for (int k = 1; k <= 12; k++) begin
            chk("single_grant", 32'(a.grant_o), 32'h1);
            chk("single_tick",  32'(a.tick_o), (k % 4 == 0) ? 32'h1 : 32'h0);
            chk("single_count", a.tick_count_o, 32'((k - 1) / 4));
            cyc();
        end
        chk("single_done",  32'(a.window_done_o), 32'h1);
        chk("single_id",    32'(a.done_id_o), 32'h0);
        chk("single_count_end", a.tick_count_o, 32'h3);
        chk("single_grant_end", 32'(a.grant_o), 32'h0);
        chk("single_busy_end",  32'(a.busy_o), 32'h0);
        $display("window done id=%0d ticks=%0d", a.done_id_o, a.tick_count_o);
        a.req_i = '0;
        cyc();
        chk("single_done_clear", 32'(a.window_done_o), 32'h0);
        chk("single_count_hold", a.tick_count_o, 32'h3);

        // Reset to return the pointer to 0, then round-robin over 1011
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        a.req_i = 4'b1011;
        cyc();
        for (int w = 0; w < 4; w++) begin
            chk("rr_grant_start", 32'(a.grant_o), 32'h1 << rr_ids[w]);
            repeat (11) cyc();
            chk("rr_grant_last", 32'(a.grant_o), 32'h1 << rr_ids[w]);
            cyc();
            chk("rr_done",      32'(a.window_done_o), 32'h1);
            chk("rr_id",        32'(a.done_id_o), 32'(rr_ids[w]));
            chk("rr_grant_gap1", 32'(a.grant_o), 32'h0);
            $display("window done id=%0d ticks=%0d", a.done_id_o, a.tick_count_o);
            cyc();
            chk("rr_done_clear", 32'(a.window_done_o), 32'h0);
            chk("rr_grant_gap2", 32'(a.grant_o), 32'h0);
            cyc();
        end
        chk("rr_grant_next", 32'(a.grant_o), 32'h2);
        a.req_i = '0;
        cyc();
        chk("rr_abort_grant", 32'(a.grant_o), 32'h0);
        chk("rr_abort_done",  32'(a.window_done_o), 32'h0);

        // Abort after 5 grant cycles; pointer moves to 2+1 = 3
        a.req_i = 4'b0100;
        cyc();
        for (int k = 1; k <= 5; k++) begin
            chk("abort_grant", 32'(a.grant_o), 32'h4);
            if (k < 5) cyc();
        end
        chk("abort_count_before", a.tick_count_o, 32'h1);
        a.req_i = '0;
        cyc();
        chk("abort_grant_clr", 32'(a.grant_o), 32'h0);
        chk("abort_busy_clr",  32'(a.busy_o), 32'h0);
        chk("abort_count_clr", a.tick_count_o, 32'h0);
        chk("abort_no_done",   32'(a.window_done_o), 32'h0);
        repeat (3) begin
            cyc();
            chk("abort_no_done_later", 32'(a.window_done_o), 32'h0);
        end
        a.req_i = 4'b1100;
        cyc();
        chk("abort_ptr_grant", 32'(a.grant_o), 32'h8);
        a.req_i = '0;
        cyc();
        chk("abort_ptr_clr", 32'(a.grant_o), 32'h0);

        // Request dropped on the completing edge: abort wins
        a.req_i = 4'b0010;
        cyc();
        chk("simul_grant", 32'(a.grant_o), 32'h2);
        repeat (11) cyc();
        chk("simul_tick12",  32'(a.tick_o), 32'h1);
        chk("simul_count12", a.tick_count_o, 32'h2);
        a.req_i = '0;
        cyc();
        chk("simul_no_done", 32'(a.window_done_o), 32'h0);
        chk("simul_grant_clr", 32'(a.grant_o), 32'h0);
        chk("simul_count_clr", a.tick_count_o, 32'h0);
        cyc();
        chk("simul_no_done_later", 32'(a.window_done_o), 32'h0);

        // Reset mid-window; pointer was 2, so 1010 grants bit 3 before reset, bit 1 after
        a.req_i = 4'b1010;
        cyc();
        chk("rstmid_grant", 32'(a.grant_o), 32'h8);
        repeat (6) cyc();
        chk("rstmid_count7", a.tick_count_o, 32'h1);
        rst_n = 1'b0;
        cyc();
        chk_a_quiet("rstmid");
        rst_n = 1'b1;
        cyc();
        chk("rstmid_regrant", 32'(a.grant_o), 32'h2);
        chk("rstmid_no_done", 32'(a.window_done_o), 32'h0);
        a.req_i = '0;
        cyc();
        chk("rstmid_release", 32'(a.grant_o), 32'h0);

        // DIV=1, WINDOW_TICKS=1
        b.req_i = 4'b0001;
        cyc();
        chk("div1_grant", 32'(b.grant_o), 32'h1);
        chk("div1_tick",  32'(b.tick_o), 32'h1);
        chk("div1_count", b.tick_count_o, 32'h0);
        cyc();
        chk("div1_done",  32'(b.window_done_o), 32'h1);
        chk("div1_id",    32'(b.done_id_o), 32'h0);
        chk("div1_count_end", b.tick_count_o, 32'h1);
        chk("div1_grant_end", 32'(b.grant_o), 32'h0);
        $display("window done id=%0d ticks=%0d (DIV=1)", b.done_id_o, b.tick_count_o);
        b.req_i = '0;
        cyc();
        chk("div1_done_clear", 32'(b.window_done_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
